// File: rtl/fifo_fsm_ctrl_pkg.sv
// fifo_fsm_ctrl_pkg: shared definitions for the FIFO controller.
//   - size defaults (DATA_W/ADDR_W/DEPTH)
//   - FSM state encodings, kept as plain 2-bit constants so they match
//     the legacy encoding used elsewhere (CLR=0, IDLE=1, WRITE=2, READ=3)
//   - last_op encoding used by the write/read contention arbiter
//   - RAM control pin bundle
package fifo_fsm_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 32;

  localparam logic [1:0] ST_CLR   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // RAM control pins; clear is active-low on the RAM side.
  typedef struct packed {
    logic ce;
    logic clear;
    logic wr_rd;
    logic oe;
  } ram_ctl_t;

endpackage

// File: rtl/fifo_fsm_ctrl_ptr_cnt.sv
// fifo_ptr_cnt: write/read pointers and occupancy count for the FIFO.
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   inc_w  : advance write pointer, count+1
//   inc_r  : advance read pointer, count-1
//   zero   : synchronous clear of pointers and count (flush)
//   wptr/rptr : RAM addresses, wrap naturally mod 2**ADDR_W
//   count  : words stored, 0..DEPTH
//   full/empty : decoded from the registered count
module fifo_ptr_cnt #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_w,
  input  logic              inc_r,
  input  logic              zero,
  output logic [ADDR_W-1:0] wptr,
  output logic [ADDR_W-1:0] rptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  always_ff @(posedge clk) begin
    if (!rst_n || zero) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (inc_w) wptr <= wptr + 1'b1;
      if (inc_r) rptr <= rptr + 1'b1;
      // The FSM never issues both in one cycle; if it did, count holds.
      if (inc_w && !inc_r)      count <= count + 1'b1;
      else if (inc_r && !inc_w) count <= count - 1'b1;
    end
  end

  assign full  = (count == (ADDR_W+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fifo_fsm_ctrl.sv
// fifo_fsm_ctrl: FSM that runs a single-port 32x8 RAM as a FIFO queue.
//   clk, Clear (sync active-low reset), flush
//   wr_req/wr_data -> wr_ack/wr_err ; rd_req -> rd_ack/rd_err
//   rd_data/rd_valid : popped word, valid for one cycle
//   full/empty/count : occupancy status
//   ram_* : RAM address, write/read, oe, ce, clear (active-low), wdata,
//           and the RAM's asynchronous read data back in ram_rdata
// Every op takes two cycles: an IDLE decision cycle and a WRITE/READ
// access cycle.
module fifo_fsm_ctrl
  import fifo_fsm_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              Clear,
  input  logic              flush,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              wr_err,
  output logic              rd_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_rd,
  output logic              ram_oe,
  output logic              ram_ce,
  output logic              ram_clear,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic [1:0]        state;
  logic              last_op;
  logic [DATA_W-1:0] wbuf;
  logic [ADDR_W-1:0] wptr, rptr;
  logic              wr_ok, rd_ok, pick_w, pick_r;
  logic              inc_w, inc_r, zero;
  ram_ctl_t          ctl;

  assign wr_ok  = wr_req && !full;
  assign rd_ok  = rd_req && !empty;
  // On contention serve the opposite of the previous op.
  assign pick_w = wr_ok && (!rd_ok || last_op == OP_READ);
  assign pick_r = rd_ok && !pick_w;

  // Pointer updates land on the exit edge of the access state; Clear=0
  // at that edge aborts the op without touching the pointers.
  assign inc_w = (state == ST_WRITE) && Clear;
  assign inc_r = (state == ST_READ)  && Clear;
  assign zero  = (state == ST_IDLE)  && flush;

  fifo_ptr_cnt #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .rst_n (Clear),
    .inc_w (inc_w),
    .inc_r (inc_r),
    .zero  (zero),
    .wptr  (wptr),
    .rptr  (rptr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (!Clear) begin
      state    <= ST_CLR;
      last_op  <= OP_READ;
      wbuf     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
      case (state)
        ST_CLR: state <= ST_IDLE;
        ST_IDLE: begin
          if (flush) begin
            state <= ST_CLR;
          end else begin
            if (pick_w) begin
              wbuf  <= wr_data;
              state <= ST_WRITE;
            end else if (pick_r) begin
              state <= ST_READ;
            end
            // A request that can't be eligible is rejected right away.
            wr_err <= wr_req && full;
            rd_err <= rd_req && empty;
          end
        end
        ST_WRITE: begin
          last_op <= OP_WRITE;
          state   <= ST_IDLE;
        end
        ST_READ: begin
          rd_data  <= ram_rdata;
          rd_valid <= 1'b1;
          last_op  <= OP_READ;
          state    <= ST_IDLE;
        end
        default: state <= ST_CLR;
      endcase
    end
  end

  // RAM pins and acks decode straight from the state register.
  always_comb begin
    ctl       = '{ce: 1'b0, clear: 1'b1, wr_rd: 1'b0, oe: 1'b0};
    ram_addr  = '0;
    ram_wdata = '0;
    wr_ack    = 1'b0;
    rd_ack    = 1'b0;
    case (state)
      ST_CLR: ctl = '{ce: 1'b1, clear: 1'b0, wr_rd: 1'b0, oe: 1'b0};
      ST_WRITE: begin
        ctl       = '{ce: 1'b1, clear: 1'b1, wr_rd: 1'b1, oe: 1'b0};
        ram_addr  = wptr;
        ram_wdata = wbuf;
        wr_ack    = 1'b1;
      end
      ST_READ: begin
        ctl      = '{ce: 1'b1, clear: 1'b1, wr_rd: 1'b0, oe: 1'b1};
        ram_addr = rptr;
        rd_ack   = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram_ce    = ctl.ce;
  assign ram_clear = ctl.clear;
  assign ram_wr_rd = ctl.wr_rd;
  assign ram_oe    = ctl.oe;

endmodule

// File: tb/tb_fifo_fsm_ctrl.sv
// tb_fifo_fsm_ctrl: directed + randomized bench for fifo_fsm_ctrl with a
// behavioural 32x8 RAM and a queue-based reference of the FIFO contents.
module tb_fifo_fsm_ctrl;

  logic       clk = 1'b0;
  logic       Clear, flush, wr_req, rd_req;
  logic [7:0] wr_data;
  logic       wr_ack, rd_ack, wr_err, rd_err, rd_valid, full, empty;
  logic [7:0] rd_data, ram_wdata, ram_rdata;
  logic [5:0] count;
  logic [4:0] ram_addr;
  logic       ram_wr_rd, ram_oe, ram_ce, ram_clear;

  fifo_fsm_ctrl dut (
    .clk(clk), .Clear(Clear), .flush(flush),
    .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_err(wr_err), .rd_err(rd_err),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count),
    .ram_addr(ram_addr), .ram_wr_rd(ram_wr_rd), .ram_oe(ram_oe),
    .ram_ce(ram_ce), .ram_clear(ram_clear), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: sync write/clear, async read.
  logic [7:0] mem [32];
  int ram_writes = 0;
  always @(posedge clk) begin
    if (ram_ce && !ram_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
    end else if (ram_ce && ram_wr_rd) begin
      mem[ram_addr] <= ram_wdata;
      ram_writes    <= ram_writes + 1;
    end
  end
  assign ram_rdata = (ram_ce && ram_oe && !ram_wr_rd) ? mem[ram_addr] : 8'h00;

  // Reference: queue of stored words, running push/pop totals for the
  // expected addresses, and which kind of op completed last.
  logic [7:0] q[$];
  int widx = 0, ridx = 0;
  bit last_w = 1'b0;
  int passed = 0, total = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete(); widx = 0; ridx = 0; last_w = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bit ok;
    ok = (q.size() < 32);
    wr_data = d; wr_req = 1'b1;
    cyc();
    chk("push_ack", wr_ack, ok);
    chk("push_err", wr_err, !ok);
    if (ok) chk("push_addr", ram_addr, widx % 32);
    wr_req = 1'b0;
    cyc();
    if (ok) begin
      q.push_back(d); widx++; last_w = 1'b1;
    end
    chk("push_ack_drop", wr_ack | wr_err, 0);
    chk("push_count", count, q.size());
    chk("push_full", full, q.size() == 32);
  endtask

  task automatic pop();
    bit ok;
    logic [7:0] exp;
    ok = (q.size() > 0);
    rd_req = 1'b1;
    cyc();
    chk("pop_ack", rd_ack, ok);
    chk("pop_err", rd_err, !ok);
    if (ok) chk("pop_addr", ram_addr, ridx % 32);
    rd_req = 1'b0;
    cyc();
    chk("pop_valid", rd_valid, ok);
    if (ok) begin
      exp = q.pop_front(); ridx++; last_w = 1'b0;
      chk("pop_data", rd_data, exp);
    end
    chk("pop_count", count, q.size());
    chk("pop_empty", empty, q.size() == 0);
  endtask

  initial begin
    bit ew, er, exp_w;
    logic [7:0] exp;
    Clear = 1'b0; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;

    // Reset held for 3 cycles, then released mid-cycle.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_ram_clear", ram_clear, 0);
      chk("rst_ram_ce", ram_ce, 1);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_outs", {wr_ack, rd_ack, wr_err, rd_err, rd_valid, full, ram_wr_rd, ram_oe}, 0);
      chk("rst_data", {rd_data, ram_addr, ram_wdata}, 0);
    end
    Clear = 1'b1;
    #1 chk("rst_tail_clear", ram_clear, 0);
    cyc();
    chk("idle_ram_clear", ram_clear, 1);
    chk("idle_ram_ce", ram_ce, 0);
    chk("idle_empty", empty, 1);
    model_reset();

    // Single push/pop of 0xA5, rd_valid must be a single-cycle pulse.
    push(8'hA5);
    pop();
    cyc();
    chk("rd_valid_pulse", rd_valid, 0);

    // Fill to 32, reject the 33rd without a RAM write, then drain.
    for (int i = 0; i < 32; i++) push(8'(i));
    chk("full_flag", full, 1);
    begin
      int rw;
      rw = ram_writes;
      push(8'hEE);
      chk("full_no_write", ram_writes, rw);
    end
    for (int i = 0; i < 32; i++) pop();
    pop();

    // Pointer wrap: 40 single push/pop pairs.
    for (int i = 0; i < 40; i++) begin
      push(8'($urandom));
      pop();
    end

    // Contention with count=5 and a read as the last op.
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
    pop();
    chk("cont_setup", count, 5);
    wr_req = 1'b1; rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_data = 8'h60 + 8'(k);
      ew = q.size() < 32; er = q.size() > 0;
      exp_w = ew && (!er || !last_w);
      cyc();
      chk("cont_wr_ack", wr_ack, exp_w);
      chk("cont_rd_ack", rd_ack, !exp_w);
      cyc();
      if (exp_w) begin
        q.push_back(wr_data); widx++; last_w = 1'b1;
      end else begin
        exp = q.pop_front(); ridx++; last_w = 1'b0;
        chk("cont_rd_data", rd_data, exp);
        chk("cont_rd_valid", rd_valid, 1);
      end
      chk("cont_count", count, q.size());
    end
    wr_req = 1'b0; rd_req = 1'b0;

    // Random mix: push-heavy phase then pop-heavy phase.
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (i < 60 ? (r < 7) : (r < 3)) push(8'($urandom));
      else if (r != 9) pop();
      else begin
        cyc();
        chk("rand_idle_count", count, q.size());
      end
    end

    // Flush at count=7.
    while (q.size() > 7) pop();
    while (q.size() < 7) push(8'($urandom));
    flush = 1'b1;
    cyc();
    chk("flush_clr", ram_clear, 0);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    flush = 1'b0;
    q.delete(); widx = 0; ridx = 0;
    cyc();
    chk("flush_idle", ram_clear, 1);
    pop();
    push(8'h3C);
    pop();

    // Clear asserted during a WRITE aborts it.
    push(8'h11);
    wr_data = 8'h77; wr_req = 1'b1;
    cyc();
    chk("abort_in_write", wr_ack, 1);
    Clear = 1'b0; wr_req = 1'b0;
    cyc();
    chk("abort_ack", wr_ack, 0);
    chk("abort_count", count, 0);
    chk("abort_ram_clear", ram_clear, 0);
    chk("abort_no_valid", rd_valid, 0);
    cyc();
    Clear = 1'b1;
    cyc();
    model_reset();
    chk("abort_idle", {ram_ce, ram_clear, empty}, 3'b011);
    push(8'h5A);
    pop();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
